// File: rtl/window_conv5x5.sv
// window_conv5x5: 5x5 signed-coefficient convolution over unsigned 8-bit windows, result at edge N+4.
// Optional macro CONV_BORDER_ZERO_EN forces outputs of windows with x<4 or y<4 to zero.
module window_conv5x5 #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int SHIFT      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [199:0] window_in,
  input  logic         window_valid,
  input  logic         coef_wr_en,
  input  logic [4:0]   coef_addr,
  input  logic [7:0]   coef_data,
  output logic [7:0]   pixel_out,
  output logic         pixel_out_valid,
  output logic         line_end,
  output logic         frame_end
);

  localparam logic signed [7:0]  COEF_ONE = 8'(32'sd1 <<< SHIFT);
  localparam logic signed [21:0] RND_BIAS = 22'(32'sd1 <<< (SHIFT - 1));
  localparam logic [10:0]        X_LAST   = 11'(IMG_WIDTH - 1);
  localparam logic [10:0]        Y_LAST   = 11'(IMG_HEIGHT - 1);

  function automatic logic signed [16:0] mul_px(input logic [7:0] px, input logic signed [7:0] c);
    logic signed [16:0] a;
    logic signed [16:0] b;
    a = $signed({9'd0, px});
    b = $signed({{9{c[7]}}, c});
    return a * b;
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [21:0] v);
    logic [7:0] r;
    if (v < 22'sd0) begin
      r = 8'd0;
    end else if (v > 22'sd255) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  logic signed [7:0]  coef_r [25];
  logic [10:0]        x_r;
  logic [10:0]        y_r;
  logic [3:0]         vld_r;
  logic [3:0]         eol_r;
  logic [3:0]         eof_r;
  logic signed [16:0] prod_r [25];
  logic signed [19:0] row_s [5];
  logic signed [19:0] row_r [5];
  logic signed [21:0] total_s;
  logic signed [21:0] total_r;
  logic signed [21:0] shifted_r;
  logic               zero_s;

  // Coefficient bank; the multiply stage samples the pre-write value on a write edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 25; k++) begin
        coef_r[k] <= (k == 12) ? COEF_ONE : 8'sd0;
      end
    end else if (coef_wr_en && (coef_addr <= 5'd24)) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Image position of the next accepted window
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= 11'd0;
      y_r <= 11'd0;
    end else if (window_valid) begin
      if (x_r == X_LAST) begin
        x_r <= 11'd0;
        y_r <= (y_r == Y_LAST) ? 11'd0 : y_r + 11'd1;
      end else begin
        x_r <= x_r + 11'd1;
      end
    end
  end

  // Valid and end-of-line/frame tags travel alongside the data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= 4'd0;
      eol_r <= 4'd0;
      eof_r <= 4'd0;
    end else begin
      vld_r <= {vld_r[2:0], window_valid};
      eol_r <= {eol_r[2:0], (x_r == X_LAST)};
      eof_r <= {eof_r[2:0], (x_r == X_LAST) && (y_r == Y_LAST)};
    end
  end

  // Adder trees for the row-sum and total stages
  always_comb begin
    total_s = 22'sd0;
    for (int r = 0; r < 5; r++) begin
      row_s[r] = 20'sd0;
      for (int c = 0; c < 5; c++) begin
        row_s[r] = row_s[r] + $signed({{3{prod_r[5*r+c][16]}}, prod_r[5*r+c]});
      end
      total_s = total_s + $signed({{2{row_r[r][19]}}, row_r[r]});
    end
  end

  // Datapath stages: multiply, row sums, total, round-and-shift
  always_ff @(posedge clk) begin
    for (int k = 0; k < 25; k++) begin
      prod_r[k] <= mul_px(window_in[8*k +: 8], coef_r[k]);
    end
    for (int r = 0; r < 5; r++) begin
      row_r[r] <= row_s[r];
    end
    total_r   <= total_s;
    shifted_r <= (total_r + RND_BIAS) >>> SHIFT;
  end

`ifdef CONV_BORDER_ZERO_EN
  logic [3:0] bdr_r;

  // Tag windows whose 5x5 footprint reaches outside the image
  always_ff @(posedge clk) begin
    if (rst) begin
      bdr_r <= 4'd0;
    end else begin
      bdr_r <= {bdr_r[2:0], (x_r < 11'd4) || (y_r < 11'd4)};
    end
  end

  assign zero_s = bdr_r[3];
`else
  assign zero_s = 1'b0;
`endif

  // Saturating output register; pixel holds across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out       <= 8'd0;
      pixel_out_valid <= 1'b0;
      line_end        <= 1'b0;
      frame_end       <= 1'b0;
    end else begin
      pixel_out_valid <= vld_r[3];
      line_end        <= vld_r[3] & eol_r[3];
      frame_end       <= vld_r[3] & eof_r[3];
      if (vld_r[3]) begin
        pixel_out <= zero_s ? 8'd0 : sat_u8(shifted_r);
      end
    end
  end

endmodule

// File: tb/tb_window_conv5x5.sv
// Directed bench for window_conv5x5: kernel vectors, streaming/position tags, coef timing, reset.
module tb_window_conv5x5;

  logic         clk = 1'b0;
  logic         rst;
  logic [199:0] window_in;
  logic         window_valid;
  logic         coef_wr_en;
  logic [4:0]   coef_addr;
  logic [7:0]   coef_data;
  logic [7:0]   pix4, pix8;
  logic         v4, v8, le4, le8, fe4, fe8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window_conv5x5 #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .window_in(window_in), .window_valid(window_valid),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .pixel_out(pix4), .pixel_out_valid(v4), .line_end(le4), .frame_end(fe4));

  window_conv5x5 #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .SHIFT(4)) dut8 (
    .clk(clk), .rst(rst), .window_in(window_in), .window_valid(window_valid),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .pixel_out(pix8), .pixel_out_valid(v8), .line_end(le8), .frame_end(fe8));

  typedef struct {
    logic [7:0]        fill;
    logic [7:0]        e12;
    logic signed [7:0] cfill;
    logic signed [7:0] c12;
    logic [7:0]        exp;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [199:0] mk_win(input logic [7:0] fill, input logic [7:0] e12);
    logic [199:0] w;
    for (int k = 0; k < 25; k++) w[8*k +: 8] = (k == 12) ? e12 : fill;
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    window_valid = 1'b1;
    window_in = mk_win(8'd200, 8'd200);
    @(negedge clk);
    rst = 1'b0;
    window_valid = 1'b0;
  endtask

  task automatic program_coefs(input logic signed [7:0] cfill, input logic signed [7:0] c12);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      coef_wr_en = 1'b1;
      coef_addr  = 5'(k);
      coef_data  = (k == 12) ? c12 : cfill;
    end
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  // One window, then exact latency check: nothing at N+3, result at N+4
  task automatic apply_one(input string nm, input logic [7:0] fill, input logic [7:0] e12, input logic [7:0] exp);
    @(negedge clk);
    window_valid = 1'b1;
    window_in = mk_win(fill, e12);
    @(negedge clk);
    window_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_early"}, v4, 1'b0);
    @(negedge clk);
    chk({nm, "_valid"}, v4, 1'b1);
    chk({nm, "_pix"}, pix4, exp);
  endtask

  // Uniform windows (identity kernel assumed), optional bubbles; checks every output cycle
  task automatic stream(input int n_win, input logic [7:0] val, input bit use8, input bit gaps, input logic [7:0] prev_pix);
    bit   vld [0:255];
    int   idx [0:255];
    int   t, placed, w, h, x, y;
    logic [7:0] last, ep, ap;
    logic av, al, af, el, ef;
    w = use8 ? 8 : 4;
    h = use8 ? 6 : 3;
    t = 0;
    placed = 0;
    while (placed < n_win) begin
      if (gaps && t > 0 && t < 200 && $urandom_range(0, 2) == 0) begin
        vld[t] = 1'b0;
      end else begin
        vld[t] = 1'b1;
        idx[t] = placed;
        placed++;
      end
      t++;
    end
    last = prev_pix;
    for (int c = 0; c < t + 6; c++) begin
      @(negedge clk);
      ap = use8 ? pix8 : pix4;
      av = use8 ? v8 : v4;
      al = use8 ? le8 : le4;
      af = use8 ? fe8 : fe4;
      if (c >= 5 && (c - 5) < t && vld[c-5]) begin
        x = idx[c-5] % w;
        y = (idx[c-5] / w) % h;
        ep = val;
`ifdef CONV_BORDER_ZERO_EN
        if (x < 4 || y < 4) ep = 8'd0;
`endif
        el = (x == w - 1);
        ef = el && (y == h - 1);
        chk("strm_valid", av, 1'b1);
        chk("strm_pix", ap, ep);
        chk("strm_line_end", al, el);
        chk("strm_frame_end", af, ef);
        last = ep;
      end else begin
        chk("strm_bubble_valid", av, 1'b0);
        chk("strm_bubble_line_end", al, 1'b0);
        chk("strm_bubble_frame_end", af, 1'b0);
        chk("strm_hold_pix", ap, last);
      end
      if (c < t) begin
        window_valid = vld[c];
        window_in = mk_win(val, val);
      end else begin
        window_valid = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{8'd0,   8'd100, 8'sd0,  8'sd16,   8'd100};
    vecs[1]  = '{8'd255, 8'd255, 8'sd1,  8'sd1,    8'd255};
    vecs[2]  = '{8'd0,   8'd50,  8'sd0,  -8'sd16,  8'd0};
    vecs[3]  = '{8'd1,   8'd1,   8'sd1,  8'sd1,    8'd2};
    vecs[4]  = '{8'd10,  8'd10,  8'sd1,  8'sd1,    8'd16};
    vecs[5]  = '{8'd0,   8'd7,   8'sd0,  8'sd1,    8'd0};
    vecs[6]  = '{8'd0,   8'd8,   8'sd0,  8'sd1,    8'd1};
    vecs[7]  = '{8'd0,   8'd255, 8'sd0,  8'sd127,  8'd255};
    vecs[8]  = '{8'd0,   8'd10,  8'sd0,  8'sd24,   8'd15};
    vecs[9]  = '{8'd0,   8'd255, 8'sd0,  -8'sd128, 8'd0};
    vecs[10] = '{8'd3,   8'd200, 8'sd1,  8'sd1,    8'd17};
    vecs[11] = '{8'd0,   8'd255, 8'sd0,  8'sd16,   8'd255};
    vecs[12] = '{8'd10,  8'd100, -8'sd1, 8'sd32,   8'd185};
    vecs[13] = '{8'd100, 8'd100, 8'sd1,  -8'sd16,  8'd50};

    rst = 1'b1;
    window_valid = 1'b1;
    window_in = mk_win(8'd100, 8'd100);
    coef_wr_en = 1'b0;
    coef_addr = 5'd0;
    coef_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_pix", pix4, 8'd0);
    chk("rst_valid", v4, 1'b0);
    chk("rst_line_end", le4, 1'b0);
    chk("rst_frame_end", fe4, 1'b0);
    rst = 1'b0;
    window_valid = 1'b0;

    // Continuous uniform stream through the identity kernel
    stream(20, 8'd100, 1'b0, 1'b0, 8'd0);

    // Line/frame tags with bubbles; 13th window starts a new frame
    do_reset();
    stream(13, 8'd60, 1'b0, 1'b1, 8'd0);

    // Border behaviour on an 8x6 image
    do_reset();
    stream(48, 8'd100, 1'b1, 1'b0, 8'd0);

    // Kernel arithmetic: rounding, signed mix, saturation both ways
    do_reset();
    for (int i = 0; i < 14; i++) begin
      program_coefs(vecs[i].cfill, vecs[i].c12);
      apply_one($sformatf("vec%0d", i), vecs[i].fill, vecs[i].e12, vecs[i].exp);
    end

    // Out-of-range coefficient addresses leave the identity kernel intact
    do_reset();
    for (int a = 25; a < 32; a++) begin
      @(negedge clk);
      coef_wr_en = 1'b1;
      coef_addr = 5'(a);
      coef_data = 8'd0;
    end
    @(negedge clk);
    coef_wr_en = 1'b0;
    apply_one("bad_addr", 8'd0, 8'd100, 8'd100);

    // Write coinciding with window A: A uses old coef, B the new one
    do_reset();
    @(negedge clk);
    window_valid = 1'b1;
    window_in = mk_win(8'd0, 8'd10);
    coef_wr_en = 1'b1;
    coef_addr = 5'd12;
    coef_data = 8'd32;
    @(negedge clk);
    coef_wr_en = 1'b0;
    @(negedge clk);
    window_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("coef_ts_a_valid", v4, 1'b1);
    chk("coef_ts_a_pix", pix4, 8'd10);
    @(negedge clk);
    chk("coef_ts_b_valid", v4, 1'b1);
    chk("coef_ts_b_pix", pix4, 8'd20);

    // Reset with three windows in flight (coef[12] still 32)
    @(negedge clk);
    window_valid = 1'b1;
    window_in = mk_win(8'd0, 8'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    window_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("flush_valid", v4, 1'b0);
      chk("flush_pix", pix4, 8'd0);
    end
    stream(8, 8'd50, 1'b0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
